// File: rtl/residual_stream_if.sv
// Pixel-in / residual-out stream bundle for residual_stream, including the
// per-block header fields that accompany the residual beats.
interface residual_stream_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int CHANNEL_W    = 8
);
  localparam int PW = NUM_CHANNELS * CHANNEL_W;
  localparam int WW = $clog2(CHANNEL_W + 1);

  logic                       in_valid;
  logic                       in_ready;
  logic [PW-1:0]              in_pixel;
  logic                       out_valid;
  logic                       out_ready;
  logic [PW-1:0]              out_data;
  logic                       out_first;
  logic                       out_last;
  logic [PW-1:0]              hdr_min;
  logic [NUM_CHANNELS-1:0]    hdr_skip;
  logic [NUM_CHANNELS*WW-1:0] hdr_width;
  logic                       hdr_compressable;

  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_data, out_first, out_last,
           hdr_min, hdr_skip, hdr_width, hdr_compressable
  );

  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_data, out_first, out_last,
           hdr_min, hdr_skip, hdr_width, hdr_compressable
  );
endinterface

// File: rtl/residual_stream.sv
// Block residual stage: buffers NUM_PIXELS pixels, derives per-channel min/width
// header, replays residuals (or raw pixels). Optional RESIDUAL_STREAM_STATS_EN.
module residual_stream #(
  parameter int NUM_PIXELS   = 32,
  parameter int NUM_CHANNELS = 4,
  parameter int CHANNEL_W    = 8,
  parameter int BIT_BUDGET   = 14
) (
  input  logic                clk,
  input  logic                rst,
  residual_stream_if.slave    bus
`ifdef RESIDUAL_STREAM_STATS_EN
  ,
  output logic [31:0]         stat_blocks,
  output logic [31:0]         stat_raw
`endif
);
  localparam int PW = NUM_CHANNELS * CHANNEL_W;
  localparam int WW = $clog2(CHANNEL_W + 1);
  localparam int CW = $clog2(NUM_PIXELS);
  localparam int SW = $clog2(NUM_CHANNELS * CHANNEL_W + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {COLLECT, COMPUTE, EMIT} state_t;

  state_t                     state;
  logic [CW-1:0]              idx;
  logic [CW-1:0]              idx_next;
  logic [PW-1:0]              buffer [NUM_PIXELS];
  logic [PW-1:0]              run_min;
  logic [PW-1:0]              run_max;
  logic                       accept;

  logic [CHANNEL_W-1:0]       diff;
  logic [WW-1:0]              width_c;
  logic [NUM_CHANNELS-1:0]    skip_all;
  logic [NUM_CHANNELS*WW-1:0] width_all;
  logic [SW-1:0]              width_sum;
  logic                       comp;
  logic [PW-1:0]              h_min;
  logic [NUM_CHANNELS-1:0]    h_skip;
  logic [NUM_CHANNELS*WW-1:0] h_width;

  function automatic logic [WW-1:0] bit_len(input logic [CHANNEL_W-1:0] v);
    logic [WW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < CHANNEL_W; i++)
      if (v[i]) r = WW'(i + 1);
    return r;
  endfunction

  function automatic logic [PW-1:0] ch_min(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW-1:0] r;
    r = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++)
      r[c*CHANNEL_W +: CHANNEL_W] = (b[c*CHANNEL_W +: CHANNEL_W] < a[c*CHANNEL_W +: CHANNEL_W])
                                    ? b[c*CHANNEL_W +: CHANNEL_W] : a[c*CHANNEL_W +: CHANNEL_W];
    return r;
  endfunction

  function automatic logic [PW-1:0] ch_max(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW-1:0] r;
    r = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++)
      r[c*CHANNEL_W +: CHANNEL_W] = (b[c*CHANNEL_W +: CHANNEL_W] > a[c*CHANNEL_W +: CHANNEL_W])
                                    ? b[c*CHANNEL_W +: CHANNEL_W] : a[c*CHANNEL_W +: CHANNEL_W];
    return r;
  endfunction

  // A raw block carries base 0, so one subtractor serves both residual and raw beats.
  function automatic logic [PW-1:0] residual(input logic [PW-1:0] pix, input logic [PW-1:0] base);
    logic [PW-1:0] r;
    r = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++)
      r[c*CHANNEL_W +: CHANNEL_W] = pix[c*CHANNEL_W +: CHANNEL_W] - base[c*CHANNEL_W +: CHANNEL_W];
    return r;
  endfunction

  assign bus.in_ready = (state == COLLECT);
  assign accept       = bus.in_valid && (state == COLLECT);
  assign idx_next     = idx + 1'b1;

  always_comb begin
    diff      = '0;
    width_c   = '0;
    skip_all  = '0;
    width_all = '0;
    width_sum = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      diff        = run_max[c*CHANNEL_W +: CHANNEL_W] - run_min[c*CHANNEL_W +: CHANNEL_W];
      width_c     = bit_len(diff);
      skip_all[c] = (diff == '0);
      width_all[c*WW +: WW] = width_c;
      width_sum   = width_sum + SW'(width_c);
    end
    comp = (32'(width_sum) <= 32'(BIT_BUDGET));
    if (comp) begin
      h_min   = run_min;
      h_skip  = skip_all;
      h_width = width_all;
    end else begin
      h_min   = '0;
      h_skip  = '0;
      h_width = '0;
      for (int unsigned c = 0; c < NUM_CHANNELS; c++)
        h_width[c*WW +: WW] = WW'(CHANNEL_W);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) buffer[idx] <= bus.in_pixel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= COLLECT;
      idx                  <= '0;
      run_min              <= '0;
      run_max              <= '0;
      bus.out_valid        <= 1'b0;
      bus.out_first        <= 1'b0;
      bus.out_last         <= 1'b0;
      bus.out_data         <= '0;
      bus.hdr_min          <= '0;
      bus.hdr_skip         <= '0;
      bus.hdr_width        <= '0;
      bus.hdr_compressable <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            if (idx == '0) begin
              run_min <= bus.in_pixel;
              run_max <= bus.in_pixel;
            end else begin
              run_min <= ch_min(run_min, bus.in_pixel);
              run_max <= ch_max(run_max, bus.in_pixel);
            end
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= COMPUTE;
            end else begin
              idx <= idx_next;
            end
          end
        end
        COMPUTE: begin
          bus.hdr_min          <= h_min;
          bus.hdr_skip         <= h_skip;
          bus.hdr_width        <= h_width;
          bus.hdr_compressable <= comp;
          // Beat 0 is preloaded here so out_valid rises the cycle after COMPUTE.
          bus.out_data         <= residual(buffer[0], h_min);
          bus.out_valid        <= 1'b1;
          bus.out_first        <= 1'b1;
          bus.out_last         <= 1'b0;
          state                <= EMIT;
        end
        EMIT: begin
          if (bus.out_ready) begin
            if (idx == LAST_IDX) begin
              bus.out_valid <= 1'b0;
              bus.out_first <= 1'b0;
              bus.out_last  <= 1'b0;
              idx           <= '0;
              state         <= COLLECT;
            end else begin
              bus.out_data  <= residual(buffer[idx_next], bus.hdr_min);
              bus.out_first <= 1'b0;
              bus.out_last  <= (idx_next == LAST_IDX);
              idx           <= idx_next;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

`ifdef RESIDUAL_STREAM_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_blocks <= '0;
      stat_raw    <= '0;
    end else if (state == COMPUTE) begin
      if (stat_blocks != '1) stat_blocks <= stat_blocks + 32'd1;
      if (!comp && stat_raw != '1) stat_raw <= stat_raw + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_residual_stream.sv
// Self-checking bench for residual_stream: directed and random blocks against
// a per-block arithmetic model, with stalls, input gaps and a mid-block reset.
module tb_residual_stream;
  localparam int NP  = 32;
  localparam int NC  = 4;
  localparam int CWD = 8;
  localparam int BB  = 14;
  localparam int PW  = NC * CWD;
  localparam int WW  = 4;

  logic clk = 1'b0;
  logic rst;

  residual_stream_if #(.NUM_CHANNELS(NC), .CHANNEL_W(CWD)) bus ();

`ifdef RESIDUAL_STREAM_STATS_EN
  logic [31:0] stat_blocks;
  logic [31:0] stat_raw;
`endif

  residual_stream #(
    .NUM_PIXELS(NP), .NUM_CHANNELS(NC), .CHANNEL_W(CWD), .BIT_BUDGET(BB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef RESIDUAL_STREAM_STATS_EN
    ,
    .stat_blocks(stat_blocks),
    .stat_raw(stat_raw)
`endif
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  logic [PW-1:0]    pix      [NP];
  logic [PW-1:0]    exp_data [NP];
  logic [PW-1:0]    exp_min;
  logic [NC-1:0]    exp_skip;
  logic [NC*WW-1:0] exp_width;
  logic             exp_comp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Header and beats from the block rules: min/max scan, bit length by power search.
  function automatic void build_model();
    int mn [NC];
    int mx [NC];
    int sum;
    int d;
    int w;
    int v;
    sum = 0;
    exp_min = '0; exp_skip = '0; exp_width = '0;
    for (int c = 0; c < NC; c++) begin
      mn[c] = 255; mx[c] = 0;
      for (int i = 0; i < NP; i++) begin
        v = int'(pix[i][c*CWD +: CWD]);
        if (v < mn[c]) mn[c] = v;
        if (v > mx[c]) mx[c] = v;
      end
      d = mx[c] - mn[c];
      w = 0;
      while ((1 << w) <= d) w++;
      sum += w;
      exp_min[c*CWD +: CWD] = 8'(mn[c]);
      exp_skip[c]           = (d == 0);
      exp_width[c*WW +: WW] = 4'(w);
    end
    exp_comp = (sum <= BB);
    if (!exp_comp) begin
      exp_min = '0;
      exp_skip = '0;
      for (int c = 0; c < NC; c++) begin
        exp_width[c*WW +: WW] = 4'(CWD);
        mn[c] = 0;
      end
    end
    for (int i = 0; i < NP; i++)
      for (int c = 0; c < NC; c++)
        exp_data[i][c*CWD +: CWD] = 8'(int'(pix[i][c*CWD +: CWD]) - mn[c]);
  endfunction

  task automatic send_pixel(input logic [PW-1:0] p);
    int g;
    g = 0;
    bus.in_valid = 1'b1;
    bus.in_pixel = p;
    while (!bus.in_ready && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    check("in_ready_wait", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_block(input bit gaps);
    for (int i = 0; i < NP; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      send_pixel(pix[i]);
    end
    check("compute_in_ready", 64'(bus.in_ready), 64'd0);
    check("compute_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    check("latency_out_valid", 64'(bus.out_valid), 64'd1);
  endtask

  // mode 0: always ready, 1: alternating starting stalled, 2: random.
  task automatic recv_block(input int mode);
    int k;
    int guard;
    bit rdy;
    bit stalled;
    logic [PW-1:0] held;
    k = 0; guard = 0; stalled = 0; held = '0;
    bus.in_valid = 1'b1;
    bus.in_pixel = PW'($urandom);
    while (k < NP && guard < 2000) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (guard % 2 == 1);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = rdy;
      if (guard == 0) begin
        check("hdr_min", 64'(bus.hdr_min), 64'(exp_min));
        check("hdr_skip", 64'(bus.hdr_skip), 64'(exp_skip));
        check("hdr_width", 64'(bus.hdr_width), 64'(exp_width));
        check("hdr_compressable", 64'(bus.hdr_compressable), 64'(exp_comp));
      end
      if (stalled) check("stall_stable", 64'(bus.out_data), 64'(held));
      check("out_valid", 64'(bus.out_valid), 64'd1);
      check("out_data", 64'(bus.out_data), 64'(exp_data[k]));
      check("out_first", 64'(bus.out_first), 64'(k == 0));
      check("out_last", 64'(bus.out_last), 64'(k == NP - 1));
      check("emit_in_ready", 64'(bus.in_ready), 64'd0);
      stalled = !rdy;
      held = bus.out_data;
      @(posedge clk); #1;
      guard++;
      if (rdy) k++;
    end
    check("beat_count", 64'(k), 64'(NP));
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("post_block_valid", 64'(bus.out_valid), 64'd0);
    check("post_block_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  function automatic void fill_test2();
    for (int i = 0; i < NP; i++)
      pix[i] = {8'(i % 16), 8'd7, 8'(i % 8), 8'(100 + i)};
  endfunction

  function automatic void fill_random();
    int base;
    int rng;
    int sel;
    for (int c = 0; c < NC; c++) begin
      base = int'($urandom_range(0, 255));
      sel  = int'($urandom_range(0, 4));
      rng  = (sel == 0) ? 0 : (sel == 1) ? 1 : (sel == 2) ? 3 : (sel == 3) ? 15 : 255;
      for (int i = 0; i < NP; i++)
        pix[i][c*CWD +: CWD] = 8'(base + int'($urandom_range(0, rng)));
    end
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, failed);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_pixel  = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_first", 64'(bus.out_first), 64'd0);
    check("rst_out_last", 64'(bus.out_last), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_hdr_min", 64'(bus.hdr_min), 64'd0);
    check("rst_hdr_skip", 64'(bus.hdr_skip), 64'd0);
    check("rst_hdr_width", 64'(bus.hdr_width), 64'd0);
    check("rst_hdr_comp", 64'(bus.hdr_compressable), 64'd0);
`ifdef RESIDUAL_STREAM_STATS_EN
    check("rst_stat_blocks", 64'(stat_blocks), 64'd0);
    check("rst_stat_raw", 64'(stat_raw), 64'd0);
`endif

    // Flat block: every channel skipped.
    for (int i = 0; i < NP; i++) pix[i] = {8'd255, 8'd30, 8'd20, 8'd10};
    build_model();
    send_block(1'b0);
    recv_block(0);
    check("t1_hdr_min", 64'(bus.hdr_min), 64'hFF1E140A);
    check("t1_hdr_skip", 64'(bus.hdr_skip), 64'hF);

    fill_test2();
    build_model();
    send_block(1'b0);
    recv_block(0);
    check("t2_hdr_width", 64'(bus.hdr_width), 64'h4035);
    check("t2_hdr_skip", 64'(bus.hdr_skip), 64'h4);

    // Sum of widths 15 exceeds the budget: raw fallback.
    for (int i = 0; i < NP; i++) pix[i] = {8'd0, 8'd0, 8'(i * 4), 8'(i * 8)};
    build_model();
    send_block(1'b0);
    recv_block(0);
    check("t3_hdr_comp", 64'(bus.hdr_compressable), 64'd0);
    check("t3_hdr_width", 64'(bus.hdr_width), 64'h8888);

`ifdef RESIDUAL_STREAM_STATS_EN
    check("stat_blocks_3", 64'(stat_blocks), 64'd3);
    check("stat_raw_1", 64'(stat_raw), 64'd1);
`endif

    fill_random();
    build_model();
    send_block(1'b0);
    recv_block(1);

    for (int b = 0; b < 6; b++) begin
      fill_random();
      build_model();
      send_block(1'b1);
      recv_block(2);
    end

    // Partial block then reset; the next block must not see stale pixels.
    fill_random();
    for (int i = 0; i < 10; i++) send_pixel(pix[i]);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_hdr_min", 64'(bus.hdr_min), 64'd0);
    check("midrst_hdr_comp", 64'(bus.hdr_compressable), 64'd0);
`ifdef RESIDUAL_STREAM_STATS_EN
    check("midrst_stat_blocks", 64'(stat_blocks), 64'd0);
    check("midrst_stat_raw", 64'(stat_raw), 64'd0);
`endif
    fill_test2();
    build_model();
    send_block(1'b0);
    recv_block(2);
    check("t5_hdr_width", 64'(bus.hdr_width), 64'h4035);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/residual_stream.md
Name: residual_stream

Overview:
- Streaming, parametrised residual stage for the block compressor.
- Accepts one multi-channel pixel per handshake beat and buffers one block of NUM_PIXELS pixels while tracking the per-channel min and max.
- Then computes per-channel min, skip flags, bit widths and the compressibility verdict against a bit budget.
- Replays the block as per-pixel residuals on a ready/valid output. Sits between the pixel ingest path and the bit packer.

Parameters:
- NUM_PIXELS, 32, pixels per block (>=2).
- NUM_CHANNELS, 4, channels per pixel (>=1).
- CHANNEL_W, 8, bits per channel (>=1).
- BIT_BUDGET, 14, max summed channel bit width for a compressible block.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  input pixel accepted when in_valid&&in_ready.
- in_pixel  in  NUM_CHANNELS*CHANNEL_W  pixel; channel c at bits [c*CHANNEL_W +: CHANNEL_W].
- out_valid  out  1  residual beat valid.
- out_ready  in  1  downstream accepts beat.
- out_data  out  NUM_CHANNELS*CHANNEL_W  residual (or raw) pixel, same packing.
- out_first  out  1  first beat of block.
- out_last  out  1  last beat of block.
- hdr_min  out  NUM_CHANNELS*CHANNEL_W  per-channel minimum.
- hdr_skip  out  NUM_CHANNELS  channel c has max==min.
- hdr_width  out  NUM_CHANNELS*$clog2(CHANNEL_W+1)  per-channel bit width.
- hdr_compressable  out  1  sum of hdr_width <= BIT_BUDGET.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high, per the fixed decision.
- FSM states and transitions:
  - COLLECT -> COMPUTE on acceptance of the NUM_PIXELS-th pixel.
  - COMPUTE -> EMIT unconditionally after 1 cycle.
  - EMIT -> COLLECT on the handshake of the beat with out_last.
- Reset: state COLLECT, pixel counter 0; out_valid, out_first, out_last 0; all hdr_* 0. Reset mid-block discards the partial block.
- in_ready = (state==COLLECT). Input is never accepted in COMPUTE or EMIT.
- COLLECT:
  - Accepted pixel is written to buffer[count].
  - First pixel of a block loads running min and max. Later pixels update them with an unsigned per-channel compare.
- COMPUTE:
  - diff_c = max_c - min_c (unsigned, CHANNEL_W bits).
  - width_c = bit length of diff_c: 0 when diff_c==0, else floor(log2 diff_c)+1. Range 0..CHANNEL_W.
  - skip_c = (diff_c==0).
  - Sum of widths uses a $clog2(NUM_CHANNELS*CHANNEL_W+1)-bit accumulator, no overflow.
  - compressable = (sum <= BIT_BUDGET).
  - All hdr_* registered here and held constant through EMIT.
- Raw fallback (new vs. previous generation): if compressable==0, hdr_min=0, hdr_skip=0 and hdr_width=CHANNEL_W for every channel, and out_data carries raw buffered pixels.
- EMIT:
  - Beat k carries buffer[k] - hdr_min (per channel, mod 2^CHANNEL_W). This never underflows for a compressible block.
  - out_first=1 on k=0; out_last=1 on k=NUM_PIXELS-1.
  - out_valid stays 1 throughout EMIT. out_data/out_first/out_last are held stable while out_valid&&!out_ready. k advances only on handshake.
- Latency: last input accepted in cycle N -> out_valid=1 at cycle N+2.
- Minimum block period: 2*NUM_PIXELS+1 cycles.
- hdr_* are valid while out_valid=1. They retain their values after the block ends until the next COMPUTE.
- in_valid while not in COLLECT is ignored (no data loss: the producer holds its pixel).

Optional Feature:
- Macro RESIDUAL_STREAM_STATS_EN.
- Defined: adds outputs stat_blocks (32) and stat_raw (32).
  - Both are counters cleared by rst.
  - stat_blocks increments at every COMPUTE; stat_raw increments at COMPUTE when compressable==0.
  - Both saturate at all-ones.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Defaults; 32 identical pixels (r=10,g=20,b=30,a=255) -> hdr_min=(10,20,30,255), hdr_skip=4'b1111, widths 0, compressable=1, 32 beats of out_data=0, out_first on beat 0, out_last on beat 31.
- r=100+i, g=i%8, b=7, a=i%16 for i=0..31 -> widths (5,3,0,4), sum 12, compressable=1, beat i out_data r=i, g=i%8, b=0, a=i%16; hdr_skip=4'b0100 (bit c = channel c, r=bit0).
- r=i*8 (diff 248), g=i*4 (diff 124), b=a=0 -> widths (8,7,0,0), sum 15 -> compressable=0; hdr_min=0, hdr_skip=0, widths all 8; out_data equals raw pixels.
- Backpressure: out_ready=1 on alternating cycles -> exactly 32 handshakes, out_data stable while stalled, in_ready=0 throughout COMPUTE/EMIT, first out_valid 2 cycles after the last input.
- Assert rst after 10 pixels accepted, then send the test-2 block -> outputs identical to test 2; no stale pixels emitted.
- With RESIDUAL_STREAM_STATS_EN, run tests 1, 2, 3 back-to-back -> stat_blocks=3, stat_raw=1; after rst both 0.
